// File: rtl/ssd_decoder.sv
// ssd_decoder: readback monitor for a multiplexed seven-segment display bus.
// Samples the active-low {an, dp, cc} lines, waits for each pattern to stay
// unchanged for STABLE_CYCLES+1 consecutive samples, then decodes the glyph
// back to a hex nibble for the selected digit and flags full-frame capture.
//
// Ports:
//   ssd_decoder_port_clk          clock, rising edge
//   ssd_decoder_port_rstn         synchronous active-low reset
//   ssd_decoder_port_cc           segment cathodes {g,f,e,d,c,b,a}, active-low
//   ssd_decoder_port_dp           decimal-point cathode, active-low
//   ssd_decoder_port_an           anodes, active-low, bit i selects digit i
//   ssd_decoder_port_value        decoded nibbles, digit i at [4i+3:4i]
//   ssd_decoder_port_dps          decoded decimal points, 1 = lit
//   ssd_decoder_port_digit_err    1 = last capture of digit i was not a glyph
//   ssd_decoder_port_frame_valid  one-cycle pulse when every digit was captured
//   ssd_decoder_port_an_err       one-cycle pulse on stable multi-anode pattern
module ssd_decoder #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  ssd_decoder_port_clk,
  input  logic                  ssd_decoder_port_rstn,
  input  logic [6:0]            ssd_decoder_port_cc,
  input  logic                  ssd_decoder_port_dp,
  input  logic [DIGITS-1:0]     ssd_decoder_port_an,
  output logic [4*DIGITS-1:0]   ssd_decoder_port_value,
  output logic [DIGITS-1:0]     ssd_decoder_port_dps,
  output logic [DIGITS-1:0]     ssd_decoder_port_digit_err,
  output logic                  ssd_decoder_port_frame_valid,
  output logic                  ssd_decoder_port_an_err
);

  localparam int unsigned SW = DIGITS + 8;

  typedef enum logic [1:0] {WAIT, COUNT, HELD} state_t;

  state_t            state;
  logic [SW-1:0]     smp;
  logic [3:0]        cnt;
  logic [DIGITS-1:0] seen;

  logic [SW-1:0]     bus;
  logic              same;
  logic              capture;
  logic [DIGITS-1:0] an_s;
  logic              dp_s;
  logic [6:0]        cc_s;
  logic              one_low;
  logic              multi_low;
  logic [4:0]        dec;
  logic [DIGITS-1:0] seen_next;

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] c);
    logic [4:0] r;
    case (c)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  assign bus  = {ssd_decoder_port_an, ssd_decoder_port_dp, ssd_decoder_port_cc};
  assign same = (bus == smp);
  assign an_s = smp[SW-1 -: DIGITS];
  assign dp_s = smp[7];
  assign cc_s = smp[6:0];

  // Fires in WAIT as well so STABLE_CYCLES=1 captures on the first equal
  // compare; for larger values C is always 0 in WAIT, so it cannot fire there.
  assign capture = same && (state != HELD) && (cnt == 4'(STABLE_CYCLES - 1));

  assign one_low   = $onehot(~an_s);
  assign multi_low = (|(~an_s)) && !one_low;
  assign dec       = decode(cc_s);

  always_comb begin
    seen_next = seen;
    if (one_low) seen_next = seen | ~an_s;
  end

  always_ff @(posedge ssd_decoder_port_clk) begin
    if (!ssd_decoder_port_rstn) begin
      state                        <= WAIT;
      smp                          <= '1;
      cnt                          <= '0;
      seen                         <= '0;
      ssd_decoder_port_value       <= '0;
      ssd_decoder_port_dps         <= '0;
      ssd_decoder_port_digit_err   <= '0;
      ssd_decoder_port_frame_valid <= 1'b0;
      ssd_decoder_port_an_err      <= 1'b0;
    end else begin
      ssd_decoder_port_frame_valid <= 1'b0;
      ssd_decoder_port_an_err      <= 1'b0;
      if (!same) begin
        smp   <= bus;
        cnt   <= '0;
        state <= WAIT;
      end else begin
        if (cnt != 4'(STABLE_CYCLES)) cnt <= cnt + 4'd1;
        if (capture)             state <= HELD;
        else if (state == WAIT)  state <= COUNT;
        if (capture) begin
          if (one_low) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (!an_s[i]) begin
                ssd_decoder_port_value[4*i +: 4] <= dec[3:0];
                ssd_decoder_port_dps[i]          <= ~dp_s;
                ssd_decoder_port_digit_err[i]    <= dec[4];
              end
            end
            if (&seen_next) begin
              ssd_decoder_port_frame_valid <= 1'b1;
              seen                         <= '0;
            end else begin
              seen <= seen_next;
            end
          end else if (multi_low) begin
            ssd_decoder_port_an_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_decoder.sv
// Testbench for ssd_decoder: directed scenarios followed by random bus
// traffic, every cycle compared against a run-length reference model.
module tb_ssd_decoder;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned ST     = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  cc;
  logic        dp;
  logic [7:0]  an;
  logic [31:0] value;
  logic [7:0]  dps;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        an_err;

  always #5 clk = ~clk;

  ssd_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(ST)) dut (
    .ssd_decoder_port_clk        (clk),
    .ssd_decoder_port_rstn       (rstn),
    .ssd_decoder_port_cc         (cc),
    .ssd_decoder_port_dp         (dp),
    .ssd_decoder_port_an         (an),
    .ssd_decoder_port_value      (value),
    .ssd_decoder_port_dps        (dps),
    .ssd_decoder_port_digit_err  (digit_err),
    .ssd_decoder_port_frame_valid(frame_valid),
    .ssd_decoder_port_an_err     (an_err)
  );

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: a pattern is captured on the edge where it has been
  // sampled for exactly ST+1 consecutive edges.
  logic [15:0] m_prev;
  int          m_run;
  logic [31:0] m_val;
  logic [7:0]  m_dps, m_err, m_seen;
  logic        m_fv, m_ae;

  int n_assert = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int ae_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] a, input logic d, input logic [6:0] c);
    logic [15:0] b;
    int lows, k, nib;
    logic bad;
    if (!r) begin
      m_val = '0; m_dps = '0; m_err = '0; m_seen = '0;
      m_fv = 1'b0; m_ae = 1'b0;
      m_prev = '1; m_run = 1;
    end else begin
      m_fv = 1'b0; m_ae = 1'b0;
      b = {a, d, c};
      if (b == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_prev = b; m_run = 1;
      end
      if (m_run == ST + 1) begin
        lows = $countones(~a);
        if (lows == 1) begin
          k = 0;
          for (int i = 0; i < 8; i++) if (!a[i]) k = i;
          nib = 0; bad = 1'b1;
          for (int g = 0; g < 16; g++) if (glyph[g] == c) begin nib = g; bad = 1'b0; end
          m_val[4*k +: 4] = 4'(nib);
          m_err[k] = bad;
          m_dps[k] = ~d;
          m_seen[k] = 1'b1;
          if (&m_seen) begin m_fv = 1'b1; m_seen = '0; end
        end else if (lows > 1) begin
          m_ae = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] a, input logic d, input logic [6:0] c);
    rstn = r; an = a; dp = d; cc = c;
    @(posedge clk);
    model_step(r, a, d, c);
    #1;
    check("value", value, m_val);
    check("dps", {24'h0, dps}, {24'h0, m_dps});
    check("digit_err", {24'h0, digit_err}, {24'h0, m_err});
    check("frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
    check("an_err", {31'h0, an_err}, {31'h0, m_ae});
    if (frame_valid === 1'b1) fv_cnt++;
    if (an_err === 1'b1) ae_cnt++;
  endtask

  task automatic hold(input logic [7:0] a, input logic d, input logic [6:0] c, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, a, d, c);
  endtask

  task automatic show_digit(input int k, input int g, input logic d, input int n);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    hold(a, d, glyph[g], n);
  endtask

  initial begin
    rstn = 1'b0; an = '1; dp = 1'b1; cc = '1;

    // Reset with random bus, then a static blank bus
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'($urandom), 1'($urandom), 7'($urandom));
    check("reset_value", value, 32'h0);
    check("reset_flags", {22'h0, dps, digit_err, frame_valid, an_err}, 32'h0);
    hold(8'hFF, 1'b1, 7'h7F, 8);

    // Full scan, glyphs 1..8, dp lit on digit 3
    fv_cnt = 0;
    for (int k = 0; k < 8; k++) show_digit(k, k + 1, (k == 3) ? 1'b0 : 1'b1, 6);
    check("scan_value", value, 32'h87654321);
    check("scan_dps", {24'h0, dps}, 32'h08);
    check("scan_fv_count", fv_cnt, 1);

    // Glitch rejection on digit 2
    show_digit(2, 10, 1'b1, 4);
    hold(8'hFF, 1'b1, 7'h7F, 1);
    check("glitch_hold", {28'h0, value[11:8]}, 32'h3);
    show_digit(2, 10, 1'b1, 5);
    check("glitch_capt", {28'h0, value[11:8]}, 32'hA);

    // Illegal glyph on digit 0, then a legal one
    hold(8'hFE, 1'b1, 7'h7F, 10);
    check("illegal_val", {28'h0, value[3:0]}, 32'h0);
    check("illegal_err", {24'h0, digit_err}, 32'h01);
    show_digit(0, 5, 1'b1, 6);
    check("legal_err", {24'h0, digit_err}, 32'h00);

    // Two anodes low, then blank
    ae_cnt = 0;
    hold(8'hFC, 1'b1, glyph[3], 6);
    check("multi_an_cnt", ae_cnt, 1);
    hold(8'hFF, 1'b1, 7'h7F, 6);

    // Reset mid-frame discards partial progress
    fv_cnt = 0;
    for (int k = 0; k < 6; k++) show_digit(k, k, 1'b1, 6);
    cycle(1'b0, 8'hFF, 1'b1, 7'h7F);
    for (int k = 6; k < 8; k++) show_digit(k, k, 1'b1, 6);
    check("midrst_no_fv", fv_cnt, 0);
    for (int k = 0; k < 8; k++) show_digit(k, 15 - k, 1'b1, 6);
    check("midrst_fv_once", fv_cnt, 1);

    // Random traffic
    for (int s = 0; s < 250; s++) begin
      logic [7:0] a;
      logic [6:0] c;
      int sel;
      if ($urandom_range(0, 49) == 0) begin
        cycle(1'b0, 8'($urandom), 1'($urandom), 7'($urandom));
        continue;
      end
      sel = int'($urandom_range(0, 9));
      a = 8'hFF;
      if (sel <= 6) a[$urandom_range(0, 7)] = 1'b0;
      else if (sel == 8) a = 8'($urandom);
      if ($urandom_range(0, 4) == 0) c = 7'($urandom);
      else c = glyph[$urandom_range(0, 15)];
      hold(a, 1'($urandom), c, int'($urandom_range(1, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_decoder.md
# ssd_decoder

Monitor/readback block for the multiplexed seven-segment display bus. It samples the active-low cathode, decimal-point and anode lines that the board drives, and waits for each digit pattern to be stable. It then decodes the segment pattern back to a hex nibble per digit and signals when a full scan frame has been captured. It sits beside the display driver as a self-check and test-observation path.

## Interface
- DIGITS, 8: number of anode lines / digit slots.
- STABLE_CYCLES, 4: consecutive unchanged cycles required before a pattern is captured. Legal range is 1..15.

- ssd_decoder_port_clk  in  1  sole clock; all state changes on rising edge.
- ssd_decoder_port_rstn  in  1  reset; synchronous, active-low.
- ssd_decoder_port_cc  in  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- ssd_decoder_port_dp  in  1  decimal-point cathode, active-low.
- ssd_decoder_port_an  in  DIGITS  anodes, active-low; bit i selects digit i.
- ssd_decoder_port_value  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- ssd_decoder_port_dps  out  DIGITS  decoded decimal points, 1 = lit.
- ssd_decoder_port_digit_err  out  DIGITS  1 = last capture for digit i was not a legal glyph.
- ssd_decoder_port_frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse or reset.
- ssd_decoder_port_an_err  out  1  one-cycle pulse when a stable bus shows more than one anode low.

## Operation
- Sample register S holds {an, dp, cc}. Stability counter C is 4 bits.
- Each edge:
  - If the bus differs from S, then S <= bus and C <= 0.
  - Otherwise C increments, saturating at STABLE_CYCLES.
- FSM states are WAIT, COUNT and HELD.
  - WAIT -> COUNT on the first equal compare.
  - COUNT -> HELD when a capture event fires.
  - Any compare mismatch -> WAIT, from any state.
  - HELD persists while the bus is unchanged, so one stable pattern yields exactly one event.
- A capture event fires when state is COUNT, the bus equals S, and C == STABLE_CYCLES-1. Classification of S.an:
  - Exactly one bit low (digit i): value[i], dps[i] and digit_err[i] update, seen[i] <= 1.
  - All bits high (blank): no update, no error.
  - Two or more bits low: an_err pulses and no digit updates.
- Decode map (cc, g..a, active-low → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
  - Any other pattern gives value nibble 0 and digit_err[i] = 1.
  - A legal pattern clears digit_err[i].
- dps[i] <= ~S.dp on capture.
- Frame logic:
  - If a capture makes seen all-ones, frame_valid <= 1 on that edge and seen <= 0 on that edge.
  - Recapturing an already-seen digit updates its value but does not affect seen.

## Timing
- Reset state (edge with rstn=0): value=0, dps=0, digit_err=0, frame_valid=0, an_err=0, S=all-ones, C=0, seen=0, state WAIT. Reset overrides any simultaneous capture.
- Latency: pattern first sampled into S at edge E0 and held → outputs update at edge E0+STABLE_CYCLES. This requires STABLE_CYCLES+1 consecutive identical samples. A shorter hold is never captured.
- frame_valid and an_err are high for exactly one cycle, registered on the capture edge.
- Reset mid-frame discards partial seen. The next frame_valid requires all DIGITS slots to be captured afresh.
- Counter saturation: C never wraps, and HELD is never re-triggered by long holds.
- Change on the exact capture edge counts as a mismatch. No capture occurs and C restarts.

## Test plan
- Reset: hold rstn=0 for 2 edges with random bus → all outputs 0; release with bus static → no outputs change until a valid stable pattern arrives.
- Full scan: DIGITS=8, STABLE_CYCLES=4. Drive digits 0..7 with glyphs for 1,2,3,4,5,6,7,8, each for 6 cycles, dp low on digit 3 → value=32'h87654321, dps=8'h08, one frame_valid pulse on the capture edge of digit 7 (4 edges after its first sample).
- Glitch rejection: digit 2 shows glyph for A for 4 cycles then changes → value[11:8] unchanged. Hold 5 cycles → value[11:8]=A exactly 4 edges after the first sample.
- Illegal glyph: an=11111110, cc=1111111 held 10 cycles → value[3:0]=0, digit_err=8'h01, single capture. Then glyph 5 → digit_err=0.
- Multi-anode: an=11111100 held 6 cycles → an_err one-cycle pulse at E0+4, no value/seen change. an=11111111 → no outputs change.
- Reset mid-frame: capture digits 0..5, pulse rstn low one edge, then capture digits 6..7 → no frame_valid. Then capture 0..7 → frame_valid pulses once.
